// File: rtl/if_id_stall_latch_if.sv
// IF/ID latch bundle: fetch-side inputs (instruction, PC+2, stall, flush) and decode-side outputs.
// master drives the fetch/hazard side; slave is the latch itself.
interface if_id_stall_latch_if #(
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
);
    logic [INSTR_W-1:0] instr_in;
    logic [INSTR_W-1:0] pc_plus2_in;
    logic               stall_in;
    logic               flush_in;
    logic [INSTR_W-1:0] instr_out;
    logic [INSTR_W-1:0] pc_plus2_out;
    logic               valid_out;
    logic               pc_write_en_out;
    logic               id_ex_bubble_out;
    logic               halted_out;
    logic [CNT_W-1:0]   stall_cnt_out;

    modport master (
        output instr_in, pc_plus2_in, stall_in, flush_in,
        input  instr_out, pc_plus2_out, valid_out, pc_write_en_out,
               id_ex_bubble_out, halted_out, stall_cnt_out
    );

    modport slave (
        input  instr_in, pc_plus2_in, stall_in, flush_in,
        output instr_out, pc_plus2_out, valid_out, pc_write_en_out,
               id_ex_bubble_out, halted_out, stall_cnt_out
    );
endinterface

// File: rtl/if_id_stall_latch.sv
// IF/ID pipeline register with stall hold, flush squash and HALT freeze; 1-cycle latency.
// Stall holds the register and gates the PC; flush always wins; HALT blocks fetch until flush or reset.
module if_id_stall_latch #(
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]         HALT_OPC  = 5'b00000,
    parameter int                 CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    if_id_stall_latch_if.slave  bus
);
    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_STALL  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]         r_state;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] r_pc_plus2;
    logic               r_valid;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic w_halted;
    logic w_bubble;
    logic w_is_halt;

    assign w_halted  = (r_state == S_HALTED);
    assign w_bubble  = ~bus.flush_in & bus.stall_in & ~w_halted;
    assign w_is_halt = (bus.instr_in[INSTR_W-1:INSTR_W-5] == HALT_OPC);

    assign bus.pc_write_en_out  = bus.flush_in | (~bus.stall_in & ~w_halted);
    assign bus.id_ex_bubble_out = w_bubble;
    assign bus.halted_out       = w_halted;
    assign bus.instr_out        = r_instr;
    assign bus.pc_plus2_out     = r_pc_plus2;
    assign bus.valid_out        = r_valid;
    assign bus.stall_cnt_out    = r_stall_cnt;

    // Flush outranks HALTED so a HALT fetched down a mispredicted path can be squashed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_RUN;
            r_instr    <= NOP_INSTR;
            r_pc_plus2 <= '0;
            r_valid    <= 1'b0;
        end else if (bus.flush_in) begin
            r_state    <= S_RUN;
            r_instr    <= NOP_INSTR;
            r_pc_plus2 <= bus.pc_plus2_in;
            r_valid    <= 1'b0;
        end else if (w_halted) begin
            r_state    <= S_HALTED;
        end else if (bus.stall_in) begin
            r_state    <= S_STALL;
        end else begin
            r_state    <= w_is_halt ? S_HALTED : S_RUN;
            r_instr    <= bus.instr_in;
            r_pc_plus2 <= bus.pc_plus2_in;
            r_valid    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_bubble && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_if_id_stall_latch.sv
// Directed + random checks of the IF/ID stall latch against a per-cycle reference model and scoreboard.
module tb_if_id_stall_latch;
    localparam logic [15:0] NOP = 16'h0800;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        valid;
        logic        halted;
        logic [3:0]  cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    logic [1:0]  m_state;
    logic [15:0] m_instr;
    logic [15:0] m_pc;
    logic        m_valid;
    logic [3:0]  m_cnt;

    if_id_stall_latch_if #(.INSTR_W(16), .CNT_W(4)) bus ();

    if_id_stall_latch #(
        .INSTR_W(16), .NOP_INSTR(16'h0800), .HALT_OPC(5'b00000), .CNT_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 2'd0;
        m_instr = NOP;
        m_pc    = 16'h0000;
        m_valid = 1'b0;
        m_cnt   = 4'h0;
    endtask

    task automatic do_reset(input string tag);
        bus.stall_in = 1'b0;
        bus.flush_in = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        chk({tag, "_instr"},  {16'h0, bus.instr_out}, {16'h0, NOP});
        chk({tag, "_valid"},  {31'h0, bus.valid_out}, 32'h0);
        chk({tag, "_cnt"},    {28'h0, bus.stall_cnt_out}, 32'h0);
        chk({tag, "_pcwe"},   {31'h0, bus.pc_write_en_out}, 32'h1);
        chk({tag, "_halted"}, {31'h0, bus.halted_out}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Drives one cycle of stimulus, checks the combinational outputs, then scores the registered outputs.
    task automatic step(input logic [15:0] ins, input logic [15:0] pc,
                        input logic st, input logic fl);
        logic pcwe_e, bub_e;
        exp_t e, got;
        bus.instr_in    = ins;
        bus.pc_plus2_in = pc;
        bus.stall_in    = st;
        bus.flush_in    = fl;
        #1;
        pcwe_e = fl | (~st & (m_state != 2'd2));
        bub_e  = ~fl & st & (m_state != 2'd2);
        chk("pc_write_en", {31'h0, bus.pc_write_en_out}, {31'h0, pcwe_e});
        chk("id_ex_bubble", {31'h0, bus.id_ex_bubble_out}, {31'h0, bub_e});
        if (fl) begin
            m_instr = NOP; m_valid = 1'b0; m_pc = pc; m_state = 2'd0;
        end else if (m_state == 2'd2) begin
            m_state = 2'd2;
        end else if (st) begin
            m_state = 2'd1;
        end else begin
            m_instr = ins; m_pc = pc; m_valid = 1'b1;
            m_state = (ins[15:11] == 5'b00000) ? 2'd2 : 2'd0;
        end
        if (bub_e && (m_cnt != 4'hF)) m_cnt = m_cnt + 4'h1;
        e.instr = m_instr; e.pc = m_pc; e.valid = m_valid;
        e.halted = (m_state == 2'd2); e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            got.instr = bus.instr_out; got.pc = bus.pc_plus2_out; got.valid = bus.valid_out;
            got.halted = bus.halted_out; got.cnt = bus.stall_cnt_out;
            chk("instr_out", {16'h0, got.instr}, {16'h0, e.instr});
            chk("pc_plus2_out", {16'h0, got.pc}, {16'h0, e.pc});
            chk("valid_out", {31'h0, got.valid}, {31'h0, e.valid});
            chk("halted_out", {31'h0, got.halted}, {31'h0, e.halted});
            chk("stall_cnt_out", {28'h0, got.cnt}, {28'h0, e.cnt});
        end
    endtask

    initial begin
        logic [15:0] r_ins;
        bus.instr_in    = 16'h0;
        bus.pc_plus2_in = 16'h0;
        bus.stall_in    = 1'b0;
        bus.flush_in    = 1'b0;
        rst = 1'b1;
        #2;
        do_reset("reset");

        // Streaming: each instruction one edge later, valid.
        step(16'h4123, 16'h0002, 1'b0, 1'b0);
        chk("stream_a", {16'h0, bus.instr_out}, 32'h4123);
        step(16'h4234, 16'h0004, 1'b0, 1'b0);
        chk("stream_b", {16'h0, bus.instr_out}, 32'h4234);
        chk("stream_valid", {31'h0, bus.valid_out}, 32'h1);

        // Two-cycle stall holding 8A20, then release.
        step(16'h8A20, 16'h0006, 1'b0, 1'b0);
        step(16'h5555, 16'h0008, 1'b1, 1'b0);
        step(16'h5555, 16'h0008, 1'b1, 1'b0);
        chk("stall_hold", {16'h0, bus.instr_out}, 32'h8A20);
        chk("stall_cnt2", {28'h0, bus.stall_cnt_out}, 32'h2);
        step(16'h5555, 16'h0008, 1'b0, 1'b0);
        chk("stall_release", {16'h0, bus.instr_out}, 32'h5555);

        // Flush and stall together: flush wins, no count.
        step(16'h6666, 16'h000A, 1'b1, 1'b1);
        chk("flush_nop", {16'h0, bus.instr_out}, 32'h0800);
        chk("flush_valid", {31'h0, bus.valid_out}, 32'h0);
        chk("flush_cnt", {28'h0, bus.stall_cnt_out}, 32'h2);

        // HALT reaches decode and holds for 10 cycles regardless of stall.
        step(16'h0000, 16'h0020, 1'b0, 1'b0);
        chk("halt_set", {31'h0, bus.halted_out}, 32'h1);
        for (int i = 0; i < 10; i++)
            step(16'h7000 + 16'(i), 16'h0022, 1'(i % 3 == 0), 1'b0);
        chk("halt_hold_instr", {16'h0, bus.instr_out}, 32'h0000);
        chk("halt_hold_flag", {31'h0, bus.halted_out}, 32'h1);
        step(16'h3333, 16'h0040, 1'b0, 1'b1);
        chk("halt_flush_nop", {16'h0, bus.instr_out}, 32'h0800);
        chk("halt_flush_clear", {31'h0, bus.halted_out}, 32'h0);

        // Counter saturation at 4'hF.
        for (int i = 0; i < 20; i++)
            step(16'h4444, 16'h0042, 1'b1, 1'b0);
        chk("sat_cnt", {28'h0, bus.stall_cnt_out}, 32'hF);
        step(16'h4444, 16'h0042, 1'b0, 1'b0);

        // Reset while halted.
        step(16'h0001, 16'h0044, 1'b0, 1'b0);
        chk("halt_again", {31'h0, bus.halted_out}, 32'h1);
        do_reset("reset_halted");

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            r_ins = 16'($urandom);
            if ($urandom_range(0, 5) != 0 && r_ins[15:11] == 5'b00000) r_ins[15] = 1'b1;
            step(r_ins, 16'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
        end

        // Reset while stalled.
        step(16'h4321, 16'h0050, 1'b0, 1'b1);
        step(16'h1234, 16'h0052, 1'b1, 1'b0);
        do_reset("reset_stalled");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
